// File: rtl/data_memory_ctrl.sv
// Byte-addressable RISC-V data memory with valid/ready request port, registered response,
// misalignment/range error reporting and a post-reset clear sequence.
module data_memory_ctrl #(
    parameter int unsigned DEPTH          = 128,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_mode,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  init_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * DEPTH);

    localparam logic [2:0] M_LB  = 3'b000;
    localparam logic [2:0] M_LH  = 3'b001;
    localparam logic [2:0] M_LW  = 3'b010;
    localparam logic [2:0] M_LBU = 3'b011;
    localparam logic [2:0] M_LHU = 3'b100;
    localparam logic [2:0] M_SB  = 3'b101;
    localparam logic [2:0] M_SH  = 3'b110;
    localparam logic [2:0] M_SW  = 3'b111;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic [31:0]     mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] diff_c;
    logic [1:0]            off_c;
    logic [AW-1:0]         word_c;
    logic [1:0]            size_c;
    logic                  is_store_c;
    logic                  err_c;
    logic                  accept_c;
    logic                  wr_en_c;
    logic [3:0]            be_base_c;
    logic [3:0]            be_c;
    logic [31:0]           wsh_c;
    logic [31:0]           lane_c;
    logic [31:0]           load_c;

    assign req_ready  = (state_q == ST_IDLE);
    assign init_done  = (state_q != ST_INIT);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

    // Request decode, lane steering and next-state logic.
    always_comb begin
        diff_c     = req_addr - BASE;
        off_c      = diff_c[1:0];
        word_c     = diff_c[AW+1:2];
        size_c     = 2'd0;
        is_store_c = 1'b0;
        case (req_mode)
            M_LH, M_LHU: size_c = 2'd1;
            M_LW:        size_c = 2'd2;
            M_SB:        is_store_c = 1'b1;
            M_SH:        begin size_c = 2'd1; is_store_c = 1'b1; end
            M_SW:        begin size_c = 2'd2; is_store_c = 1'b1; end
            default:     size_c = 2'd0;
        endcase

        err_c = (req_addr < BASE) || (diff_c >= SPAN)
              || ((size_c == 2'd1) && off_c[0])
              || ((size_c == 2'd2) && (off_c != 2'd0));

        accept_c = req_valid && (state_q == ST_IDLE);
        wr_en_c  = accept_c && is_store_c && !err_c;

        case (size_c)
            2'd1:    be_base_c = 4'b0011;
            2'd2:    be_base_c = 4'b1111;
            default: be_base_c = 4'b0001;
        endcase
        be_c  = be_base_c << off_c;
        wsh_c = req_wdata << {off_c, 3'b000};

        lane_c = mem_q[word_c] >> {off_c, 3'b000};
        case (req_mode)
            M_LB:    load_c = {{24{lane_c[7]}}, lane_c[7:0]};
            M_LH:    load_c = {{16{lane_c[15]}}, lane_c[15:0]};
            M_LW:    load_c = lane_c;
            M_LBU:   load_c = {24'd0, lane_c[7:0]};
            M_LHU:   load_c = {16'd0, lane_c[15:0]};
            default: load_c = 32'd0;
        endcase

        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        resp_valid_d = accept_c;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        if (state_q == ST_INIT) begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end
        end

        if (accept_c) begin
            resp_data_d = (err_c || is_store_c) ? 32'd0 : load_c;
            resp_err_d  = err_c;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            clr_ptr_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage: cleared word-by-word in INIT, byte-lane writes in IDLE.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == ST_INIT) begin
                mem_q[clr_ptr_q] <= 32'd0;
            end else if (wr_en_c) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_c[b]) begin
                        mem_q[word_c][8*b +: 8] <= wsh_c[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: expected responses queued on issue, checked on resp_valid.
module tb_data_memory_ctrl;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b011;
    localparam logic [2:0] LHU = 3'b100;
    localparam logic [2:0] SB  = 3'b101;
    localparam logic [2:0] SH  = 3'b110;
    localparam logic [2:0] SW  = 3'b111;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_mode;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        init_done;

    int          n_vec;
    int          n_err;
    logic [32:0] sb_q[$];
    string       tag_q[$];

    data_memory_ctrl #(
        .DEPTH(128), .ADDR_WIDTH(32), .BASE_ADDR(0), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mode(req_mode), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: predict resp_valid from what is presented, then check it and any response.
    task automatic tick();
        logic        exp_v;
        logic [32:0] e;
        string       t;
        exp_v = req_valid && req_ready && reset_n;
        @(posedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(exp_v));
        if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL sb_underflow observed=resp_valid expected=no_response");
            end else begin
                e = sb_q.pop_front();
                t = tag_q.pop_front();
                chk({t, "_data"}, resp_data, e[32:1]);
                chk({t, "_err"}, 32'(resp_err), 32'(e[0]));
            end
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data,
                         input logic exp_err);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wdata;
        sb_q.push_back({exp_data, exp_err});
        tag_q.push_back(tag);
        tick();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        req_valid = 1'b0;
        while (req_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_cycles"}, 32'(n), 32'd128);
        chk({tag, "_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_mode  = LW;
        req_wdata = 32'd0;

        // Reset state and clear sequence.
        tick();
        tick();
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        reset_n = 1'b1;
        wait_init("init1");
        issue("lw_1fc_clr", LW, 32'h1FC, 32'd0, 32'h0000_0000, 1'b0);

        // Word store, byte overwrite, load-after-store.
        issue("sw_10", SW, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
        issue("sb_11", SB, 32'h11, 32'h0000_005A, 32'd0, 1'b0);
        issue("lw_10", LW, 32'h10, 32'd0, 32'hDEAD_5AEF, 1'b0);

        // Sign/zero extension.
        issue("sw_10b", SW, 32'h10, 32'h80FF_7F01, 32'd0, 1'b0);
        issue("lb_13", LB, 32'h13, 32'd0, 32'hFFFF_FF80, 1'b0);
        issue("lbu_13", LBU, 32'h13, 32'd0, 32'h0000_0080, 1'b0);
        issue("lh_12", LH, 32'h12, 32'd0, 32'hFFFF_80FF, 1'b0);
        issue("lhu_12", LHU, 32'h12, 32'd0, 32'h0000_80FF, 1'b0);
        issue("lb_11", LB, 32'h11, 32'd0, 32'h0000_007F, 1'b0);
        issue("lh_10", LH, 32'h10, 32'd0, 32'h0000_7F01, 1'b0);

        // Error cases must not touch memory and must return zero data.
        issue("sw_20", SW, 32'h20, 32'h1122_3344, 32'd0, 1'b0);
        issue("lw_20a", LW, 32'h20, 32'd0, 32'h1122_3344, 1'b0);
        issue("lh_21", LH, 32'h21, 32'd0, 32'd0, 1'b1);
        issue("lw_22", LW, 32'h22, 32'd0, 32'd0, 1'b1);
        issue("sw_200", SW, 32'h200, 32'h9999_9999, 32'd0, 1'b1);
        issue("sh_23", SH, 32'h23, 32'h0000_FFFF, 32'd0, 1'b1);
        issue("sw_22", SW, 32'h22, 32'h5555_5555, 32'd0, 1'b1);
        issue("lw_20b", LW, 32'h20, 32'd0, 32'h1122_3344, 1'b0);
        issue("lw_0", LW, 32'h0, 32'd0, 32'h0000_0000, 1'b0);
        issue("lb_200", LB, 32'h200, 32'd0, 32'd0, 1'b1);
        idle(2);

        // Back-to-back alternating stream, then response hold.
        issue("st_sw_40", SW, 32'h40, 32'hAAAA_5555, 32'd0, 1'b0);
        issue("st_lw_44", LW, 32'h44, 32'd0, 32'h0000_0000, 1'b0);
        issue("st_sw_44", SW, 32'h44, 32'h1234_5678, 32'd0, 1'b0);
        issue("st_lw_40", LW, 32'h40, 32'd0, 32'hAAAA_5555, 1'b0);
        idle(1);
        chk("hold_data", resp_data, 32'hAAAA_5555);
        chk("hold_err", 32'(resp_err), 32'd0);

        // Half/byte lanes in the upper half of a word.
        issue("sh_46", SH, 32'h46, 32'hFFFF_BEEF, 32'd0, 1'b0);
        issue("lhu_46", LHU, 32'h46, 32'd0, 32'h0000_BEEF, 1'b0);
        issue("lw_44a", LW, 32'h44, 32'd0, 32'hBEEF_5678, 1'b0);
        issue("sb_47", SB, 32'h47, 32'hFFFF_FF01, 32'd0, 1'b0);
        issue("lw_44b", LW, 32'h44, 32'd0, 32'h01EF_5678, 1'b0);

        // Last word of the array.
        issue("sw_1fc", SW, 32'h1FC, 32'hCAFE_F00D, 32'd0, 1'b0);
        issue("lb_1ff", LB, 32'h1FF, 32'd0, 32'hFFFF_FFCA, 1'b0);
        issue("lbu_1fc", LBU, 32'h1FC, 32'd0, 32'h0000_000D, 1'b0);
        issue("lhu_1fe", LHU, 32'h1FE, 32'd0, 32'h0000_CAFE, 1'b0);
        idle(1);

        // Reset with a request presented, then reset again mid-clear.
        req_valid = 1'b1;
        req_mode  = SW;
        req_addr  = 32'h10;
        req_wdata = 32'hFFFF_FFFF;
        reset_n   = 1'b0;
        tick();
        chk("rst2_ready", 32'(req_ready), 32'd0);
        chk("rst2_init_done", 32'(init_done), 32'd0);
        chk("rst2_resp_data", resp_data, 32'd0);
        reset_n   = 1'b1;
        req_valid = 1'b0;
        repeat (50) tick();
        chk("mid_ready", 32'(req_ready), 32'd0);
        chk("mid_init_done", 32'(init_done), 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wait_init("init2");
        issue("lw_10_clr", LW, 32'h10, 32'd0, 32'h0000_0000, 1'b0);
        issue("lw_1fc_clr2", LW, 32'h1FC, 32'd0, 32'h0000_0000, 1'b0);
        idle(1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
